// File: rtl/ifid_skid_buffer_pkg.sv
// Shared datapath types for the fetch/decode boundary.
// Holds the word type, the skid-buffer entry layout and its depth.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IFID_DEPTH = 2;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_entry_t;

  function automatic ifid_entry_t make_entry(input word_t instr, input word_t pc,
                                             input word_t npc);
    ifid_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.npc   = npc;
    return e;
  endfunction

endpackage

// File: rtl/ifid_skid_buffer_if.sv
// Fetch/decode boundary bundle: fetch-side enqueue, decode-side head, control and perf.
// slave = the skid buffer, master = the surrounding pipeline (or a bench).
interface ifid_skid_buffer_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  word_t imemaddr;
  word_t next_memaddr;
  logic  flush;
  logic  dec_stall;
  logic  halt;
  logic  fetch_stall;
  logic  id_valid;
  word_t id_instr;
  word_t id_pc;
  word_t id_npc;
  logic  halted;
  word_t perf_bubble_cnt;
  word_t perf_full_cnt;

  modport slave (
    input  ihit, imemload, imemaddr, next_memaddr, flush, dec_stall, halt,
    output fetch_stall, id_valid, id_instr, id_pc, id_npc, halted,
           perf_bubble_cnt, perf_full_cnt
  );

  modport master (
    output ihit, imemload, imemaddr, next_memaddr, flush, dec_stall, halt,
    input  fetch_stall, id_valid, id_instr, id_pc, id_npc, halted,
           perf_bubble_cnt, perf_full_cnt
  );

endinterface

// File: rtl/ifid_skid_buffer_perf_ctr.sv
// 32-bit free-wrapping enable counter used for the optional perf statistics.
// Latency: count visible the cycle after the enabled edge; no backpressure.
module ifid_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifid_skid_buffer.sv
// Two-entry fetch->decode instruction skid buffer with flush and sticky halt; perf counters under IFID_PERF_EN.
// Latency: enqueue to id_valid is 1 cycle; 1 instr/cycle sustained with one entry held.
// Backpressure: fetch_stall is purely registered (full or halted); a hit while full is dropped for fetch to replay.
module ifid_skid_buffer
  import cpu_types_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  ifid_skid_buffer_if.slave bus
);

  ifid_entry_t entry [IFID_DEPTH];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        halted_q;
  logic        full;
  logic        empty;
  logic        enq;
  logic        deq;
  ifid_entry_t head;

  assign full  = (count == 2'(IFID_DEPTH));
  assign empty = (count == 2'd0);

  // Enqueue is gated on registered fullness only, so dec_stall never reaches fetch_stall.
  assign enq = bus.ihit & ~full & ~bus.flush & ~halted_q;
  assign deq = ~empty & ~bus.dec_stall & ~bus.flush & ~halted_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < IFID_DEPTH; i++) begin
        entry[i] <= '0;
      end
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (enq) begin
          entry[wr_ptr] <= make_entry(bus.imemload, bus.imemaddr, bus.next_memaddr);
          wr_ptr        <= ~wr_ptr;
        end
        if (deq) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, enq} - {1'b0, deq};
      end
      if (bus.halt) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign head            = entry[rd_ptr];
  assign bus.id_valid    = ~empty;
  assign bus.id_instr    = head.instr;
  assign bus.id_pc       = head.pc;
  assign bus.id_npc      = head.npc;
  assign bus.fetch_stall = full | halted_q;
  assign bus.halted      = halted_q;

`ifdef IFID_PERF_EN
  ifid_perf_ctr u_bubble_ctr (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (empty & ~halted_q),
    .cnt   (bus.perf_bubble_cnt)
  );

  ifid_perf_ctr u_full_ctr (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (full & ~halted_q),
    .cnt   (bus.perf_full_cnt)
  );
`else
  assign bus.perf_bubble_cnt = '0;
  assign bus.perf_full_cnt   = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_buffer.sv
// Scoreboard bench for ifid_skid_buffer: stimulus pushes accepted words, a negedge monitor checks each dequeue.
module tb_ifid_skid_buffer;
  import cpu_types_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  ifid_entry_t exp_q[$];

  ifid_skid_buffer_if ifc ();

  ifid_skid_buffer dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hit(input word_t instr, input word_t pc, input word_t npc,
                           input bit accept);
    ifc.ihit         = 1'b1;
    ifc.imemload     = instr;
    ifc.imemaddr     = pc;
    ifc.next_memaddr = npc;
    if (accept) exp_q.push_back(make_entry(instr, pc, npc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_id_valid"}, {31'd0, ifc.id_valid}, 32'd0);
    chk({tag, "_id_instr"}, ifc.id_instr, 32'd0);
    chk({tag, "_id_pc"}, ifc.id_pc, 32'd0);
    chk({tag, "_id_npc"}, ifc.id_npc, 32'd0);
    chk({tag, "_fetch_stall"}, {31'd0, ifc.fetch_stall}, 32'd0);
    chk({tag, "_halted"}, {31'd0, ifc.halted}, 32'd0);
    chk({tag, "_perf_bubble"}, ifc.perf_bubble_cnt, 32'd0);
    chk({tag, "_perf_full"}, ifc.perf_full_cnt, 32'd0);
  endtask

  // Monitor: a dequeue happens at the next edge exactly when these conditions hold.
  initial begin
    ifid_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.id_valid && !ifc.dec_stall && !ifc.flush && !ifc.halted) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dequeue_pc", ifc.id_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("deq_instr", ifc.id_instr, e.instr);
          chk("deq_pc", ifc.id_pc, e.pc);
          chk("deq_npc", ifc.id_npc, e.npc);
        end
      end
    end
  end

  word_t stream_instr [3];
  word_t exp_bubble;
  word_t exp_full;

  initial begin
    n_cmp = 0;
    n_err = 0;
    stream_instr[0] = 32'h2001_0001;
    stream_instr[1] = 32'h2002_0002;
    stream_instr[2] = 32'h0022_1820;
`ifdef IFID_PERF_EN
    exp_bubble = 32'd5;
    exp_full   = 32'd3;
`else
    exp_bubble = 32'd0;
    exp_full   = 32'd0;
`endif
    rst_n            = 1'b0;
    ifc.ihit         = 1'b0;
    ifc.imemload     = '0;
    ifc.imemaddr     = '0;
    ifc.next_memaddr = '0;
    ifc.flush        = 1'b0;
    ifc.dec_stall    = 1'b0;
    ifc.halt         = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Streaming at one word per cycle never fills the buffer.
    for (int i = 0; i < 3; i++) begin
      drive_hit(stream_instr[i], word_t'(4 * i), word_t'(4 * i + 4), 1'b1);
      tick();
      chk("stream_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd0);
    end
    ifc.ihit = 1'b0;
    tick();
    tick();
    chk("stream_drained", {31'd0, ifc.id_valid}, 32'd0);

    // Fill under decode stall; third hit is refused until replayed.
    ifc.dec_stall = 1'b1;
    drive_hit(32'hAAAA_0010, 32'h10, 32'h14, 1'b1);
    tick();
    chk("fill1_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd0);
    drive_hit(32'hAAAA_0014, 32'h14, 32'h18, 1'b1);
    tick();
    chk("fill2_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd1);
    chk("fill2_head_pc", ifc.id_pc, 32'h10);
    drive_hit(32'hAAAA_0018, 32'h18, 32'h1C, 1'b0);
    tick();
    chk("full_ignored_stall", {31'd0, ifc.fetch_stall}, 32'd1);
    chk("full_ignored_head", ifc.id_pc, 32'h10);
    ifc.dec_stall = 1'b0;
    tick();
    chk("unfull_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd0);
    drive_hit(32'hAAAA_0018, 32'h18, 32'h1C, 1'b1);
    tick();
    ifc.ihit = 1'b0;
    tick();
    tick();
    chk("replay_drained", {31'd0, ifc.id_valid}, 32'd0);

    // Flush at full together with a hit.
    ifc.dec_stall = 1'b1;
    drive_hit(32'hBBBB_0020, 32'h20, 32'h24, 1'b1);
    tick();
    drive_hit(32'hBBBB_0024, 32'h24, 32'h28, 1'b1);
    tick();
    chk("preflush_full", {31'd0, ifc.fetch_stall}, 32'd1);
    drive_hit(32'hBBBB_0028, 32'h28, 32'h2C, 1'b0);
    ifc.flush = 1'b1;
    exp_q.delete();
    tick();
    ifc.flush = 1'b0;
    ifc.ihit  = 1'b0;
    chk("flush_id_valid", {31'd0, ifc.id_valid}, 32'd0);
    chk("flush_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd0);
    ifc.dec_stall = 1'b0;
    drive_hit(32'hCCCC_0040, 32'h40, 32'h44, 1'b1);
    tick();
    ifc.ihit = 1'b0;
    chk("post_flush_valid", {31'd0, ifc.id_valid}, 32'd1);
    chk("post_flush_pc", ifc.id_pc, 32'h40);
    tick();
    chk("post_flush_alone", {31'd0, ifc.id_valid}, 32'd0);

    // Halt with one entry held.
    ifc.dec_stall = 1'b1;
    drive_hit(32'hDDDD_0050, 32'h50, 32'h54, 1'b1);
    tick();
    ifc.ihit = 1'b0;
    ifc.halt = 1'b1;
    tick();
    ifc.halt = 1'b0;
    chk("halt_halted", {31'd0, ifc.halted}, 32'd1);
    chk("halt_fetch_stall", {31'd0, ifc.fetch_stall}, 32'd1);
    chk("halt_head_pc", ifc.id_pc, 32'h50);
    ifc.dec_stall = 1'b0;
    drive_hit(32'hDDDD_0054, 32'h54, 32'h58, 1'b0);
    repeat (3) tick();
    chk("halt_frozen_pc", ifc.id_pc, 32'h50);
    chk("halt_frozen_valid", {31'd0, ifc.id_valid}, 32'd1);
    chk("halt_sticky", {31'd0, ifc.halted}, 32'd1);

    // Asynchronous reset mid-cycle, no clock edge needed.
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    ifc.ihit      = 1'b0;
    ifc.dec_stall = 1'b1;
    tick();
    rst_n = 1'b1;

    // Five idle edges, then fill and hold full for three edges.
    repeat (5) tick();
    chk("perf_bubble", ifc.perf_bubble_cnt, exp_bubble);
    drive_hit(32'h8C22_0004, 32'h0, 32'h4, 1'b1);
    tick();
    chk("first_valid", {31'd0, ifc.id_valid}, 32'd1);
    chk("first_instr", ifc.id_instr, 32'h8C22_0004);
    chk("first_pc", ifc.id_pc, 32'h0);
    chk("first_npc", ifc.id_npc, 32'h4);
    drive_hit(32'h8C23_0008, 32'h4, 32'h8, 1'b1);
    tick();
    ifc.ihit = 1'b0;
    chk("perf_fill_stall", {31'd0, ifc.fetch_stall}, 32'd1);
    repeat (3) tick();
    chk("perf_full", ifc.perf_full_cnt, exp_full);

    ifc.dec_stall = 1'b0;
    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifid_skid_buffer.md
# ifid_skid_buffer

Two-entry instruction skid buffer between the fetch stage and decode in the pipelined datapath. Captures each instruction word returned on an instruction-memory hit, with its PC and PC+4, and presents them in order to decode through a valid/stall handshake. Back-pressure is returned to fetch as a registered-state stall. Supports redirect flush and a sticky halt freeze.

## Interface
Parameters:
- none; depth is fixed by package constant `IFID_DEPTH` = 2.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `ihit`  in  1  instruction memory returned a word this cycle (enqueue request).
- `imemload`  in  32 (`word_t`)  instruction word.
- `imemaddr`  in  32 (`word_t`)  PC of that word, from fetch.
- `next_memaddr`  in  32 (`word_t`)  PC+4 of that word, from fetch.
- `flush`  in  1  control-flow redirect; discard all buffered and incoming words.
- `dec_stall`  in  1  decode cannot accept the head this cycle.
- `halt`  in  1  halt detected downstream; freeze the buffer.
- `fetch_stall`  out  1  buffer cannot accept; fetch holds its PC.
- `id_valid`  out  1  head entry valid.
- `id_instr`  out  32  head instruction.
- `id_pc`  out  32  head PC.
- `id_npc`  out  32  head PC+4.
- `halted`  out  1  sticky halt state.
- `perf_bubble_cnt`  out  32  cycles with `id_valid`=0 (perf build only).
- `perf_full_cnt`  out  32  cycles with `fetch_stall`=1 (perf build only).

## Operation
- State: `entry[0..1]` (type `ifid_entry_t`), 1-bit `rd_ptr`, 1-bit `wr_ptr`, 2-bit `count` (0..2), `halted`.
- `enq` = `ihit` & `count`!=2 & !`flush` & !`halted`.
- `deq` = `count`!=0 & !`dec_stall` & !`flush` & !`halted`.
- `enq`: write `{imemload, imemaddr, next_memaddr}` at `wr_ptr`; `wr_ptr` toggles.
- `deq`: `rd_ptr` toggles.
- `count` next = `count` + `enq` − `deq`. Simultaneous `enq` and `deq` at `count`=1 keeps `count` at 1.
- Full (`count`=2): `enq` is blocked even if `deq` occurs in the same cycle. This avoids a combinational path from `dec_stall` to `fetch_stall`. An `ihit` arriving while full is ignored; fetch re-presents it because `fetch_stall`=1.
- Empty: `id_valid`=0; `id_*` show the stale `entry[rd_ptr]`, which decode must ignore.
- `flush`: next cycle `count`=0 and `rd_ptr`=`wr_ptr`=0. The same-cycle `ihit` word is dropped and no dequeue occurs.
- `halt`: `halted` is set next cycle and stays set until reset. Once halted, no `enq` or `deq`, and `fetch_stall`=1.
- `halt` and `flush` asserted together: the buffer empties and `halted` is set.
- Outputs:
  - `id_valid` = `count`!=0.
  - `id_*` = `entry[rd_ptr]`.
  - `fetch_stall` = (`count`=2) | `halted`.
  - All outputs derive from registers only.

## Timing
- Reset (async, `nRST`=0):
  - `count`, `rd_ptr`, `wr_ptr`, `halted` = 0.
  - All entries = 0.
  - So `id_valid`=0, `id_instr`/`id_pc`/`id_npc`=0, `fetch_stall`=0, `halted`=0, perf counters 0.
- Reset asserted mid-operation clears everything immediately, with no clock required.
- Enqueue-to-`id_valid` latency: 1 cycle.
- Throughput: 1 instruction/cycle at steady state with `count`=1.
- `fetch_stall` rises the cycle after the second un-dequeued enqueue. It falls the cycle after a dequeue from full.
- `flush` takes effect at the next edge: `id_valid`=0 the cycle after `flush`.

## Configuration
- `IFID_PERF_EN` defined:
  - `perf_bubble_cnt` increments every cycle with `id_valid`=0 and !`halted`.
  - `perf_full_cnt` increments every cycle with `fetch_stall`=1 and !`halted`.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: both ports stay present and are tied to 0; no counter flops.

## Structure
- In `cpu_types_pkg`:
  - `typedef struct packed { word_t instr; word_t pc; word_t npc; } ifid_entry_t`.
  - `localparam IFID_DEPTH = 2`.
- Sub-module `ifid_perf_ctr`: a single 32-bit enable counter, instanced twice under `IFID_PERF_EN`.

## Test plan
- Reset with `nRST`=0 mid-traffic → all outputs 0 immediately; first `ihit` (`imemload`=0x8C220004, `imemaddr`=0x0) gives `id_valid`=1, `id_instr`=0x8C220004, `id_pc`=0, `id_npc`=4 next cycle.
- Streaming `ihit` every cycle with `dec_stall`=0, PCs 0x0,0x4,0x8 → in-order output one per cycle, `fetch_stall` never asserted.
- Hold `dec_stall`=1 with 3 hits at PCs 0x10,0x14,0x18 → `fetch_stall`=1 after the 2nd; 0x18 is ignored until re-presented. Release → outputs 0x10, 0x14, then 0x18.
- At `count`=2, pulse `flush` together with `ihit` → next cycle `id_valid`=0, `fetch_stall`=0; a new hit at 0x40 appears alone.
- `halt`=1 with `count`=1 → `halted`=1, `fetch_stall`=1; `id_pc` frozen under further `ihit` and `dec_stall`=0; only reset clears it.
- With `IFID_PERF_EN`, 5 idle cycles then full for 3 cycles → `perf_bubble_cnt`=5, `perf_full_cnt`=3; without the macro both read 0.
